// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch front-end: FIFO entry layout,
// fetch FSM encoding and the sequential PC increment.
package riscv_fetch_pkg;

   localparam int FETCH_XLEN = 32;
   localparam int PC_STEP    = 4;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [31:0]           instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word fall-through FIFO of fetched instructions; flush empties it
// in one cycle and wins over push/pop.
module fetch_fifo
   import riscv_fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   // DEPTH is a power of two, so the count MSB alone marks full
   assign full    = count[AW];
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: single outstanding imem request, buffered into fetch_fifo
// toward decode. Define FETCH_PERF_EN to add fetch/bubble counters.
module fetch_queue
   import riscv_fetch_pkg::*;
#(
   parameter int              XLEN     = FETCH_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instruction
`ifdef FETCH_PERF_EN
  ,output logic [31:0]     fetch_count,
   output logic [31:0]     bubble_count
`endif
);

   fetch_state_t           state_q, state_d;
   logic [XLEN-1:0]        fetch_pc, req_pc;
   logic                   push;
   fetch_entry_t           push_entry, head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   fifo_full, fifo_empty;
   logic                   unused_ok;

   assign unused_ok     = &{1'b0, redirect_pc[1:0], fifo_count};
   assign imem_req_addr = fetch_pc;
   assign push_entry    = '{pc: req_pc, instr: imem_resp_data};

   always_comb begin
      state_d        = state_q;
      imem_req_valid = 1'b0;
      push           = 1'b0;
      case (state_q)
         RUN: begin
            // In RUN nothing is outstanding, so a free slot is the whole credit check
            imem_req_valid = ~fifo_full & ~redirect_valid & ~reset;
            if (imem_req_valid && imem_req_ready) state_d = WAIT;
         end
         WAIT: if (imem_resp_valid) begin
            push    = 1'b1;
            state_d = RUN;
         end
         DROP: if (imem_resp_valid) state_d = RUN;
         default: state_d = RUN;
      endcase
      if (redirect_valid) begin
         push    = 1'b0;
         state_d = (state_q != RUN && !imem_resp_valid) ? DROP : RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
      end else begin
         state_q <= state_d;
         if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
         end else if (imem_req_valid && imem_req_ready) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(PC_STEP);
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (id_valid & id_ready),
      .flush     (redirect_valid),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Head is masked while empty so stale storage never leaks to decode
   assign id_valid       = ~fifo_empty;
   assign id_pc          = fifo_empty ? '0 : head.pc;
   assign id_instruction = fifo_empty ? '0 : head.instr;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count  <= '0;
         bubble_count <= '0;
      end else begin
         if (push)                  fetch_count  <= fetch_count + 32'd1;
         if (id_ready && !id_valid) bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus queues expected requests and
// decode handshakes, a monitor pops and compares them as the DUT presents them.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid, id_ready;
   logic [31:0] id_pc, id_instruction;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, bubble_count;
`endif

   int          n_cmp = 0, n_bad = 0;
   int          grants = 0, lat = 1;
   logic [63:0] exp_q[$];
   logic [31:0] exp_addr[$];

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_pc           (id_pc),
      .id_instruction  (id_instruction)
`ifdef FETCH_PERF_EN
     ,.fetch_count     (fetch_count),
      .bubble_count    (bubble_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp_v);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic give(input int g);
      @(negedge clk);
      grants = g;
   endtask

   task automatic expect_fetch(input logic [31:0] a, input bit delivered);
      exp_addr.push_back(a);
      if (delivered) exp_q.push_back({a, 16'hC0DE, a[15:0]});
   endtask

   // Returns 1 time unit after the edge that accepted the next request
   task automatic wait_accept();
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         seen = imem_req_valid && imem_req_ready;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_accept: no request accepted, want one within 60 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drained(input string name);
      @(negedge clk);
      chk({name, "_resp_left"}, exp_q.size(), 0);
      chk({name, "_req_left"}, exp_addr.size(), 0);
   endtask

   // Memory: grants bound how many requests it accepts; data = {C0DE, addr[15:0]}
   initial begin : mem_model
      logic        acc;
      logic [31:0] a, pa;
      int          cnt;
      bit          pend;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      pend = 1'b0; cnt = 0; pa = '0;
      forever begin
         @(negedge clk);
         acc = imem_req_valid && imem_req_ready;
         a   = imem_req_addr;
         @(posedge clk);
         #1;
         imem_resp_valid = 1'b0;
         if (acc) begin
            pend = 1'b1; cnt = lat; pa = a; grants--;
         end else if (pend) cnt--;
         if (pend && cnt <= 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = {16'hC0DE, pa[15:0]};
            pend = 1'b0;
         end
         imem_req_ready = (grants > 0);
      end
   end

   initial begin : monitor
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) begin
            if (exp_addr.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL req_addr: got unexpected request %h, want none", imem_req_addr);
            end else chk("req_addr", imem_req_addr, exp_addr.pop_front());
         end
         if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL id_out: got unexpected pc %h, want none", id_pc);
            end else begin
               e = exp_q.pop_front();
               chk("id_pc", id_pc, e[63:32]);
               chk("id_instruction", id_instruction, e[31:0]);
            end
         end
      end
   end

   initial begin : stim
      id_ready = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
      chk("rst_id_valid", {31'b0, id_valid}, 0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_instr", id_instruction, 32'h0);
      cyc(1);
      reset = 1'b0;

      // Streaming from RESET_PC
      id_ready = 1'b1;
      expect_fetch(32'h0, 1); expect_fetch(32'h4, 1); expect_fetch(32'h8, 1);
      give(3);
      cyc(12);
      drained("stream");

      // Decode stalled: FIFO fills to DEPTH, head held
      id_ready = 1'b0;
      expect_fetch(32'hC, 1); expect_fetch(32'h10, 1);
      expect_fetch(32'h14, 1); expect_fetch(32'h18, 1);
      give(10);
      cyc(14);
      @(negedge clk);
      chk("full_req_valid", {31'b0, imem_req_valid}, 0);
      chk("full_id_valid", {31'b0, id_valid}, 1);
      chk("full_id_pc", id_pc, 32'hC);
      give(0);
      cyc(3);
      @(negedge clk);
      chk("hold_id_pc", id_pc, 32'hC);
      chk("hold_id_instr", id_instruction, 32'hC0DE_000C);
      cyc(1);
      id_ready = 1'b1;
      cyc(8);
      drained("stall");

      // Redirect while waiting on a 2-cycle response
      lat = 2;
      expect_fetch(32'h1C, 0); expect_fetch(32'h100, 1); expect_fetch(32'h104, 1);
      give(3);
      wait_accept();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("redir_gate", {31'b0, imem_req_valid}, 0);
      cyc(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("drop_id_valid", {31'b0, id_valid}, 0);
      chk("drop_req_valid", {31'b0, imem_req_valid}, 0);
      cyc(14);
      drained("redir_wait");

      // Redirect coinciding with a response and a pop
      lat = 1;
      id_ready = 1'b0;
      expect_fetch(32'h108, 1); expect_fetch(32'h10C, 0);
      give(2);
      wait_accept();
      wait_accept();
      redirect_valid = 1'b1; redirect_pc = 32'h300; id_ready = 1'b1;
      cyc(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("coinc_id_valid", {31'b0, id_valid}, 0);
      expect_fetch(32'h300, 1);
      give(1);
      cyc(8);
      drained("redir_coinc");

      // Misaligned redirect target, offered with memory ready
      expect_fetch(32'h200, 1);
      give(1);
      cyc(1);
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      chk("align_gate", {31'b0, imem_req_valid}, 0);
      cyc(1);
      redirect_valid = 1'b0;
      cyc(8);
      drained("align");

      // Reset while waiting, response landing on the reset edge
      expect_fetch(32'h204, 0);
      give(1);
      wait_accept();
      reset = 1'b1;
      cyc(1);
      @(negedge clk);
      chk("rst2_req_valid", {31'b0, imem_req_valid}, 0);
      chk("rst2_id_valid", {31'b0, id_valid}, 0);
      chk("rst2_id_pc", id_pc, 32'h0);
      chk("rst2_id_instr", id_instruction, 32'h0);
      cyc(1);
      reset = 1'b0;
      expect_fetch(32'h0, 1);
      give(1);
      cyc(8);
      drained("rst_wait");
`ifdef FETCH_PERF_EN
      chk("fetch_count", fetch_count, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
